uart_rx_sched: RTL and testbench
================================

# uart_rx_sched

Receive-side controller for the UART receiver datapath. It arms the receiver through its enable/busy interface and detects frame end from the receiver's activity flag. Each completed frame is captured, masked to the configured width and tagged with its parity-error status, then buffered in a small FIFO read by the bus-side consumer over a valid/ready handshake. It also keeps sticky overflow and arm-timeout status and a saturating parity-error counter.

## Interface
- DEPTH, 8: FIFO entries; power of two, 2..64.
- ARM_TIMEOUT, 65535: max cycles in ARM waiting for rx_flag before abort; 1..65535.
- clk  input  1  system clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  level; 1 = keep receiving frames back-to-back.
- cfg_data_num  input  4  frame width code n; frame holds n+1 data bits, at rx_data[n:0].
- clr  input  1  one-cycle pulse; clears ovf, arm_to, err_cnt.
- rx_en  output  1  receiver enable (drives receiver uart_en).
- rx_busy  input  1  receiver busy.
- rx_flag  input  1  receiver active (non-idle).
- rx_err_flag  input  1  receiver parity error for current frame.
- rx_data  input  16  receiver shift register.
- rd_valid  output  1  FIFO head valid.
- rd_ready  input  1  consumer accepts head.
- rd_data  output  16  head data, masked.
- rd_err  output  1  head parity-error tag.
- fifo_cnt  output  $clog2(DEPTH)+1  occupancy.
- ovf  output  1  sticky: a frame was dropped due to full FIFO.
- arm_to  output  1  sticky: ARM timeout occurred.
- err_cnt  output  8  saturating count of frames with parity error.

## Operation
- States: IDLE, ARM, WAIT, PUSH.
- IDLE: rx_en=0. If enable=1 and rx_busy=0, go to ARM next cycle.
- ARM: rx_en=1.
  - rx_flag=1: go to WAIT.
  - ARM_TIMEOUT cycles elapse in ARM without rx_flag: set arm_to, go to IDLE.
  - enable dropping in ARM does not abort; the arm completes or times out.
- WAIT: rx_en=0. In the first cycle rx_flag=0:
  - register rx_data and rx_err_flag; this cycle is mandatory because the receiver clears its error flag one cycle after going idle;
  - go to PUSH.
- PUSH, one cycle:
  - write {err, rx_data & ((17'd2<<n)-1)} into the FIFO; mask arithmetic is 17-bit, so n=15 passes all 16 bits;
  - if the err tag is set, increment err_cnt, saturating at 255;
  - then go to IDLE.
- FIFO write is accepted if fifo_cnt<DEPTH, or if a pop occurs in the same cycle. Otherwise the frame is dropped, ovf is set and fifo_cnt is unchanged.
- Pop = rd_valid & rd_ready. Pointers wrap modulo DEPTH. rd_valid = (fifo_cnt!=0). rd_data/rd_err show the head entry combinationally from FIFO storage.
- clr in the same cycle as a set event: the set wins for ovf/arm_to. For err_cnt, clr to 0 then the increment applies, giving 1.
- rst mid-frame: controller returns to IDLE and the FIFO is emptied. A frame in flight is lost; WAIT is not re-entered until a fresh ARM.

## Timing
- Reset values: rx_en=0, rd_valid=0, rd_data=0, rd_err=0, fifo_cnt=0, ovf=0, arm_to=0, err_cnt=0, state IDLE.
- rx_en is registered; it rises one cycle after enable is sampled in IDLE.
- Frame-end to rd_valid: capture cycle (rx_flag low) → PUSH next cycle → rd_valid high the cycle after PUSH. Latency is 2 cycles.
- Re-arm: IDLE is entered after PUSH; rx_en rises 2 cycles after PUSH when enable=1.
- The arm timeout counter resets on ARM entry and counts every cycle in ARM.

## Configuration
- UART_RX_PARITY_DROP_EN:
  - defined: frames with err tag set are not written to the FIFO; err_cnt still increments; rd_err is tied 0.
  - undefined: all frames are written with their err tag.

## Test plan
- enable=1, n=7, receiver frame 0xA5 with no error → one entry, rd_data=0x00A5, rd_err=0, rd_valid 2 cycles after rx_flag falls.
- n=3, rx_data=0xFFFF at capture → rd_data=0x000F; n=15 → 0xFFFF.
- 9 frames with rd_ready=0, DEPTH=8 → fifo_cnt=8, ovf=1, the 9th frame is lost; drain returns the first 8 in order.
- Full FIFO with a pop in the PUSH cycle → write accepted, fifo_cnt stays 8, ovf=0.
- rx_flag held 0 in ARM with ARM_TIMEOUT=16 → arm_to=1 after 16 cycles, state IDLE, then re-arm.
- Parity-error frame → err_cnt=1, rd_err=1. With UART_RX_PARITY_DROP_EN: no entry, err_cnt=1. clr → err_cnt=0, ovf=0.

Source files
------------

// File: rtl/uart_rx_sched.sv
// uart_rx_sched: arms the UART receiver, captures frames into a FIFO, tracks overflow/timeout/parity status (option UART_RX_PARITY_DROP_EN).
module uart_rx_sched #(
  parameter int DEPTH = 8,
  parameter int ARM_TIMEOUT = 65535
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [3:0]               cfg_data_num,
  input  logic                     clr,
  output logic                     rx_en,
  input  logic                     rx_busy,
  input  logic                     rx_flag,
  input  logic                     rx_err_flag,
  input  logic [15:0]              rx_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [15:0]              rd_data,
  output logic                     rd_err,
  output logic [$clog2(DEPTH):0]   fifo_cnt,
  output logic                     ovf,
  output logic                     arm_to,
  output logic [7:0]               err_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  typedef enum logic [1:0] {IDLE, ARM, WAIT, PUSH} state_t;
  state_t state, next;
  logic [15:0] tcnt, cap_data, mask;
  logic cap_err, timeout, push, pop, wr, drop, inc;
  logic [7:0] err_base;
  logic [AW-1:0] wp, rp;
  logic [16:0] mem [DEPTH];
  always_comb begin
    next = state;
    case (state)
      IDLE: next = (enable && !rx_busy) ? ARM : IDLE;
      ARM:  next = rx_flag ? WAIT : (timeout ? IDLE : ARM);
      WAIT: next = rx_flag ? WAIT : PUSH;
      PUSH: next = IDLE;
      default: next = IDLE;
    endcase
  end
  assign timeout = (state == ARM) && !rx_flag && (tcnt == 16'(ARM_TIMEOUT - 1));
`ifdef UART_RX_PARITY_DROP_EN
  assign push = (state == PUSH) && !cap_err;
  assign rd_err = 1'b0;
`else
  assign push = (state == PUSH);
  assign rd_err = rd_valid & mem[rp][16];
`endif
  assign pop = rd_valid & rd_ready;
  // a pop in the same cycle frees a slot, so a full FIFO still accepts
  assign wr = push && ((fifo_cnt != FULL) || pop);
  assign drop = push && !wr;
  assign inc = (state == PUSH) && cap_err;
  assign err_base = clr ? 8'd0 : err_cnt;
  assign mask = 16'((17'd2 << cfg_data_num) - 17'd1);
  assign rd_valid = (fifo_cnt != '0);
  assign rd_data = rd_valid ? mem[rp][15:0] : 16'd0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rx_en <= 1'b0;
      tcnt <= 16'd0;
      cap_data <= 16'd0;
      cap_err <= 1'b0;
      wp <= '0;
      rp <= '0;
      fifo_cnt <= '0;
      ovf <= 1'b0;
      arm_to <= 1'b0;
      err_cnt <= 8'd0;
    end else begin
      state <= next;
      rx_en <= (next == ARM);
      tcnt <= (state == ARM) ? tcnt + 16'd1 : 16'd0;
      if (state == WAIT && !rx_flag) begin
        cap_data <= rx_data;
        cap_err <= rx_err_flag;
      end
      if (wr) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      fifo_cnt <= fifo_cnt + CW'(wr) - CW'(pop);
      ovf <= drop | (ovf & !clr);
      arm_to <= timeout | (arm_to & !clr);
      err_cnt <= err_base + 8'(inc && (err_base != 8'hFF));
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= {cap_err, cap_data & mask};
  end
endmodule

// File: tb/tb_uart_rx_sched.sv
// tb_uart_rx_sched: scoreboard bench driving a modelled receiver into uart_rx_sched.
module tb_uart_rx_sched;
  logic clk = 0, rst = 1, enable = 0, clr = 0, rx_busy = 0, rx_flag = 0, rx_err_flag = 0, rd_ready = 0;
  logic [3:0] cfg_data_num = 4'd7;
  logic [15:0] rx_data = 0;
  logic rx_en, rd_valid, rd_err, ovf, arm_to;
  logic [15:0] rd_data;
  logic [3:0] fifo_cnt;
  logic [7:0] err_cnt;
  int passed = 0, total = 0;
  logic [16:0] q[$];

  uart_rx_sched #(.DEPTH(8), .ARM_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .cfg_data_num(cfg_data_num), .clr(clr),
    .rx_en(rx_en), .rx_busy(rx_busy), .rx_flag(rx_flag), .rx_err_flag(rx_err_flag),
    .rx_data(rx_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_err(rd_err), .fifo_cnt(fifo_cnt), .ovf(ovf), .arm_to(arm_to), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [15:0] d, input logic e, input logic pop_p, input logic clr_p);
    int w;
    logic [15:0] m;
    logic [16:0] h;
    bit was_empty;
    m = 16'd0;
    for (int i = 0; i <= int'(cfg_data_num); i++) m[i] = 1'b1;
    enable = 1;
    w = 0;
    while (!rx_en && w < 40) begin tick(); w++; end
    total++;
    if (rx_en !== 1'b1) begin $display("FAIL arm_wait rx_en=%b required 1", rx_en); enable = 0; return; end
    passed++;
    rx_flag = 1; rx_busy = 1; enable = 0;
    tick();
    rx_data = d; rx_err_flag = e;
    tick(); tick();
    rx_flag = 0;
    was_empty = (q.size() == 0);
    tick();
    rx_busy = 0; rx_err_flag = 0; rx_data = 16'($urandom);
    if (pop_p) begin
      rd_ready = 1;
      h = q.pop_front();
      total++;
      if ({rd_err, rd_data} !== h) $display("FAIL push_pop_head got=%h required=%h", {rd_err, rd_data}, h);
      else passed++;
    end
    if (clr_p) clr = 1;
    if (was_empty) begin
      total++;
      if (rd_valid !== 1'b0) $display("FAIL latency_early rd_valid=%b required 0", rd_valid);
      else passed++;
    end
`ifdef UART_RX_PARITY_DROP_EN
    if (!e && q.size() < 8) q.push_back({1'b0, d & m});
`else
    if (q.size() < 8) q.push_back({e, d & m});
`endif
    tick();
    rd_ready = 0; clr = 0;
    total++;
    if (fifo_cnt !== 4'(q.size())) $display("FAIL fifo_cnt got=%0d required=%0d", fifo_cnt, q.size());
    else passed++;
    total++;
    if (rd_valid !== (q.size() != 0)) $display("FAIL rd_valid got=%b required=%b", rd_valid, q.size() != 0);
    else passed++;
  endtask

  task automatic drain();
    logic [16:0] h;
    rd_ready = 1;
    while (q.size() != 0) begin
      h = q.pop_front();
      total++;
      if (rd_valid !== 1'b1 || {rd_err, rd_data} !== h)
        $display("FAIL drain_head valid=%b got=%h required=%h", rd_valid, {rd_err, rd_data}, h);
      else passed++;
      tick();
    end
    rd_ready = 0;
    total++;
    if (fifo_cnt !== 4'd0 || rd_valid !== 1'b0) $display("FAIL drain_empty cnt=%0d valid=%b required 0/0", fifo_cnt, rd_valid);
    else passed++;
  endtask

  task automatic pulse_clr();
    clr = 1; tick(); clr = 0;
  endtask

  task automatic test_reset();
    rst = 1; tick(); tick(); tick(); rst = 0;
    total++;
    if ({rx_en, rd_valid, rd_err, ovf, arm_to} !== 5'b0) $display("FAIL reset_flags got=%b required=00000", {rx_en, rd_valid, rd_err, ovf, arm_to});
    else passed++;
    total++;
    if (rd_data !== 16'd0 || fifo_cnt !== 4'd0 || err_cnt !== 8'd0) $display("FAIL reset_values data=%h cnt=%0d err=%0d required 0", rd_data, fifo_cnt, err_cnt);
    else passed++;
  endtask

  task automatic test_basic();
    cfg_data_num = 4'd7;
    enable = 1;
    total++;
    if (rx_en !== 1'b0) $display("FAIL rx_en_pre got=%b required 0", rx_en);
    else passed++;
    tick();
    total++;
    if (rx_en !== 1'b1) $display("FAIL rx_en_rise got=%b required 1", rx_en);
    else passed++;
    send_frame(16'h3CA5, 1'b0, 1'b0, 1'b0);
    total++;
    if (rd_data !== 16'h00A5 || rd_err !== 1'b0) $display("FAIL basic_data got=%h/%b required 00a5/0", rd_data, rd_err);
    else passed++;
    drain();
  endtask

  task automatic test_mask();
    cfg_data_num = 4'd3; send_frame(16'hFFFF, 1'b0, 1'b0, 1'b0);
    cfg_data_num = 4'd15; send_frame(16'hFFFF, 1'b0, 1'b0, 1'b0);
    cfg_data_num = 4'd0; send_frame(16'hBEEF, 1'b0, 1'b0, 1'b0);
    cfg_data_num = 4'd11; send_frame(16'h9ABC, 1'b0, 1'b0, 1'b0);
    drain();
  endtask

  task automatic test_overflow();
    cfg_data_num = 4'd7;
    for (int i = 0; i < 9; i++) send_frame(16'(16'h40 + i), 1'b0, 1'b0, 1'b0);
    total++;
    if (ovf !== 1'b1 || fifo_cnt !== 4'd8) $display("FAIL overflow ovf=%b cnt=%0d required 1/8", ovf, fifo_cnt);
    else passed++;
    drain();
    pulse_clr();
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 8; i++) send_frame(16'(16'h70 + i), 1'b0, 1'b0, 1'b0);
    send_frame(16'h00EE, 1'b0, 1'b1, 1'b0);
    total++;
    if (ovf !== 1'b0 || fifo_cnt !== 4'd8) $display("FAIL full_pop ovf=%b cnt=%0d required 0/8", ovf, fifo_cnt);
    else passed++;
    drain();
  endtask

  task automatic test_timeout();
    int w, n;
    pulse_clr();
    enable = 1;
    w = 0;
    while (!rx_en && w < 40) begin tick(); w++; end
    enable = 0;
    n = 0;
    while (rx_en && n < 40) begin n++; tick(); end
    total++;
    if (n != 16 || arm_to !== 1'b1) $display("FAIL arm_timeout cycles=%0d arm_to=%b required 16/1", n, arm_to);
    else passed++;
    send_frame(16'h0033, 1'b0, 1'b0, 1'b0);
    total++;
    if (arm_to !== 1'b1) $display("FAIL arm_to_sticky got=%b required 1", arm_to);
    else passed++;
    drain();
    pulse_clr();
    total++;
    if (arm_to !== 1'b0) $display("FAIL arm_to_clr got=%b required 0", arm_to);
    else passed++;
  endtask

  task automatic test_parity();
    send_frame(16'h0055, 1'b1, 1'b0, 1'b0);
    total++;
    if (err_cnt !== 8'd1) $display("FAIL err_cnt_inc got=%0d required 1", err_cnt);
    else passed++;
    send_frame(16'h0066, 1'b1, 1'b0, 1'b1);
    total++;
    if (err_cnt !== 8'd1) $display("FAIL err_cnt_clr_inc got=%0d required 1", err_cnt);
    else passed++;
    send_frame(16'h0077, 1'b1, 1'b0, 1'b0);
    total++;
    if (err_cnt !== 8'd2) $display("FAIL err_cnt_inc2 got=%0d required 2", err_cnt);
    else passed++;
    drain();
    pulse_clr();
    total++;
    if (err_cnt !== 8'd0 || ovf !== 1'b0) $display("FAIL clr_status err=%0d ovf=%b required 0/0", err_cnt, ovf);
    else passed++;
  endtask

  task automatic test_rst_mid();
    int w;
    enable = 1;
    w = 0;
    while (!rx_en && w < 40) begin tick(); w++; end
    rx_flag = 1; rx_busy = 1; enable = 0; rx_data = 16'h00AA;
    tick(); tick();
    rst = 1; tick(); rst = 0;
    rx_flag = 0; rx_busy = 0;
    tick(); tick(); tick();
    total++;
    if (fifo_cnt !== 4'd0 || rd_valid !== 1'b0 || rx_en !== 1'b0) $display("FAIL rst_mid cnt=%0d valid=%b rx_en=%b required 0/0/0", fifo_cnt, rd_valid, rx_en);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mask();
    test_overflow();
    test_full_pop();
    test_timeout();
    test_parity();
    test_rst_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
